// File: rtl/uartio_pkg.sv
// Shared definitions for the uartio peripheral: register offsets, STAT/CTRL
// bit positions, serial FSM state encoding and the bus access record.
package uartio_pkg;

  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_STAT = 3'd1;
  localparam logic [2:0] REG_CTRL = 3'd2;
  localparam logic [2:0] REG_DIVL = 3'd3;
  localparam logic [2:0] REG_DIVH = 3'd4;

  localparam int STAT_RXAV   = 0;
  localparam int STAT_TXSP   = 1;
  localparam int STAT_OVR    = 2;
  localparam int STAT_FERR   = 3;
  localparam int STAT_TXIDLE = 4;
  localparam int STAT_IRQ    = 7;

  localparam int CTRL_RXIE  = 0;
  localparam int CTRL_TXIE  = 1;
  localparam int CTRL_FLUSH = 7;

  typedef enum logic [1:0] {SER_IDLE, SER_START, SER_DATA, SER_STOP} ser_st_t;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [2:0] ad;
    logic [7:0] di;
  } bus_req_t;

endpackage

// File: rtl/uartio_fifo.sv
// Byte FIFO with push/pop/flush; DEPTH_AW==0 collapses to one holding register.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module uartio_fifo #(
  parameter int DEPTH_AW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  generate
    if (DEPTH_AW == 0) begin : g_hold
      logic       vld;
      logic [7:0] data;
      logic       do_pop, do_push;

      assign do_pop  = pop & vld;
      assign do_push = push & (~vld | do_pop);

      always_ff @(posedge clk) begin
        if (!rst || flush) vld <= 1'b0;
        else               vld <= do_push | (vld & ~do_pop);
      end

      always_ff @(posedge clk) begin
        if (do_push) data <= din;
      end

      assign dout  = data;
      assign full  = vld;
      assign empty = ~vld;
    end else begin : g_ring
      localparam int DEPTH = 1 << DEPTH_AW;
      logic [7:0]          mem [DEPTH];
      logic [DEPTH_AW-1:0] wp, rp;
      logic [DEPTH_AW:0]   cnt;
      logic                do_pop, do_push;

      assign do_pop  = pop & (cnt != '0);
      assign do_push = push & (~cnt[DEPTH_AW] | do_pop);

      // flush outranks a same-cycle push
      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          wp  <= '0;
          rp  <= '0;
          cnt <= '0;
        end else begin
          if (do_push) wp <= wp + 1'b1;
          if (do_pop)  rp <= rp + 1'b1;
          cnt <= cnt + {{DEPTH_AW{1'b0}}, do_push} - {{DEPTH_AW{1'b0}}, do_pop};
        end
      end

      always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
      end

      assign dout  = mem[rp];
      assign full  = cnt[DEPTH_AW];
      assign empty = (cnt == '0);
    end
  endgenerate

endmodule

// File: rtl/uartio.sv
// 8N1 UART on the SuperIO bus with buffered RX/TX and maskable irq.
// Define UARTIO_FIFO_EN for 2**FIFO_AW deep buffers; otherwise each buffer holds one byte.
module uartio
  import uartio_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = 16'd103,
  parameter int          FIFO_AW     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  input  logic       rxd,
  output logic       txd
);

`ifdef UARTIO_FIFO_EN
  localparam int BUF_AW = FIFO_AW;
`else
  localparam int BUF_AW = 0;
`endif

  bus_req_t   req;
  logic       ctrl_wr, flush, tx_push, rx_pop;
  logic [15:0] div;
  logic       rx_ie, tx_ie, ovr, ferr, tx_idle;
  logic [7:0] rx_dout, tx_dout;
  logic       rx_full, rx_empty, tx_full, tx_empty;

  assign req     = '{rd: cs & rw, wr: cs & ~rw, ad: AD, di: DI};
  assign ctrl_wr = req.wr && (req.ad == REG_CTRL);
  assign flush   = ctrl_wr && req.di[CTRL_FLUSH];
  assign tx_push = req.wr && (req.ad == REG_DATA);
  assign rx_pop  = req.rd && (req.ad == REG_DATA) && !rx_empty;

  // ---------------- TX ----------------
  ser_st_t     tx_st, tx_st_n;
  logic [15:0] tx_tmr, tx_tmr_n, tx_div, tx_div_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic        tx_pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_st  <= SER_IDLE;
      tx_tmr <= '0;
      tx_div <= '0;
      tx_sh  <= '0;
      tx_bit <= '0;
    end else begin
      tx_st  <= tx_st_n;
      tx_tmr <= tx_tmr_n;
      tx_div <= tx_div_n;
      tx_sh  <= tx_sh_n;
      tx_bit <= tx_bit_n;
    end
  end

  always_comb begin
    tx_st_n  = tx_st;
    tx_tmr_n = tx_tmr;
    tx_div_n = tx_div;
    tx_sh_n  = tx_sh;
    tx_bit_n = tx_bit;
    tx_pop   = 1'b0;
    case (tx_st)
      SER_IDLE:  tx_pop = !tx_empty;
      SER_START: if (tx_tmr == '0) begin
                   tx_st_n  = SER_DATA;
                   tx_tmr_n = tx_div;
                   tx_bit_n = '0;
                 end else tx_tmr_n = tx_tmr - 16'd1;
      SER_DATA:  if (tx_tmr == '0) begin
                   tx_tmr_n = tx_div;
                   tx_sh_n  = {1'b0, tx_sh[7:1]};
                   tx_bit_n = tx_bit + 3'd1;
                   if (tx_bit == 3'd7) tx_st_n = SER_STOP;
                 end else tx_tmr_n = tx_tmr - 16'd1;
      SER_STOP:  if (tx_tmr == '0) begin
                   tx_st_n = SER_IDLE;
                   tx_pop  = !tx_empty;
                 end else tx_tmr_n = tx_tmr - 16'd1;
      default:   tx_st_n = SER_IDLE;
    endcase
    // a queued byte chains straight into the next start bit
    if (tx_pop) begin
      tx_st_n  = SER_START;
      tx_div_n = div;
      tx_tmr_n = div;
      tx_sh_n  = tx_dout;
    end
  end

  always_comb begin
    case (tx_st)
      SER_START: txd = 1'b0;
      SER_DATA:  txd = tx_sh[0];
      default:   txd = 1'b1;
    endcase
  end

  assign tx_idle = (tx_st == SER_IDLE) && tx_empty;

  // ---------------- RX ----------------
  ser_st_t     rx_st, rx_st_n;
  logic [15:0] rx_tmr, rx_tmr_n, rx_div, rx_div_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [2:0]  rx_sync;
  logic        rx_in, rx_fall, rx_push, rx_ovr_set, rx_ferr_set;

  assign rx_in   = rx_sync[1];
  assign rx_fall = rx_sync[2] & ~rx_sync[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_sync <= 3'b111;
      rx_st   <= SER_IDLE;
      rx_tmr  <= '0;
      rx_div  <= '0;
      rx_sh   <= '0;
      rx_bit  <= '0;
    end else begin
      rx_sync <= {rx_sync[1:0], rxd};
      rx_st   <= rx_st_n;
      rx_tmr  <= rx_tmr_n;
      rx_div  <= rx_div_n;
      rx_sh   <= rx_sh_n;
      rx_bit  <= rx_bit_n;
    end
  end

  always_comb begin
    rx_st_n     = rx_st;
    rx_tmr_n    = rx_tmr;
    rx_div_n    = rx_div;
    rx_sh_n     = rx_sh;
    rx_bit_n    = rx_bit;
    rx_push     = 1'b0;
    rx_ovr_set  = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_st)
      SER_IDLE:  if (rx_fall) begin
                   rx_st_n  = SER_START;
                   rx_div_n = div;
                   rx_tmr_n = {1'b0, div[15:1]};
                 end
      SER_START: if (rx_tmr == '0) begin
                   if (!rx_in) begin
                     rx_st_n  = SER_DATA;
                     rx_tmr_n = rx_div;
                     rx_bit_n = '0;
                   end else rx_st_n = SER_IDLE;
                 end else rx_tmr_n = rx_tmr - 16'd1;
      SER_DATA:  if (rx_tmr == '0) begin
                   rx_tmr_n = rx_div;
                   rx_sh_n  = {rx_in, rx_sh[7:1]};
                   rx_bit_n = rx_bit + 3'd1;
                   if (rx_bit == 3'd7) rx_st_n = SER_STOP;
                 end else rx_tmr_n = rx_tmr - 16'd1;
      SER_STOP:  if (rx_tmr == '0) begin
                   rx_st_n     = SER_IDLE;
                   rx_ferr_set = !rx_in;
                   if (rx_full && !rx_pop) rx_ovr_set = 1'b1;
                   else                    rx_push    = 1'b1;
                 end else rx_tmr_n = rx_tmr - 16'd1;
      default:   rx_st_n = SER_IDLE;
    endcase
  end

  uartio_fifo #(.DEPTH_AW(BUF_AW)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .flush(flush),
    .din(rx_sh), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  uartio_fifo #(.DEPTH_AW(BUF_AW)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(flush),
    .din(req.di), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      div   <= DEFAULT_DIV;
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
      ovr   <= 1'b0;
      ferr  <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (req.wr && req.ad == REG_DIVL) div[7:0]  <= req.di;
      if (req.wr && req.ad == REG_DIVH) div[15:8] <= req.di;
      if (ctrl_wr) begin
        rx_ie <= req.di[CTRL_RXIE];
        tx_ie <= req.di[CTRL_TXIE];
      end
      ovr  <= !flush && (ovr | rx_ovr_set);
      ferr <= !flush && (ferr | rx_ferr_set);
      irq  <= (rx_ie & ~rx_empty) | (tx_ie & tx_idle) | ovr | ferr;
    end
  end

  always_comb begin
    DO = 8'h00;
    case (req.ad)
      REG_DATA: DO = rx_empty ? 8'h00 : rx_dout;
      REG_STAT: begin
        DO[STAT_RXAV]   = ~rx_empty;
        DO[STAT_TXSP]   = ~tx_full;
        DO[STAT_OVR]    = ovr;
        DO[STAT_FERR]   = ferr;
        DO[STAT_TXIDLE] = tx_idle;
        DO[STAT_IRQ]    = irq;
      end
      REG_CTRL: begin
        DO[CTRL_RXIE] = rx_ie;
        DO[CTRL_TXIE] = tx_ie;
      end
      REG_DIVL: DO = div[7:0];
      REG_DIVH: DO = div[15:8];
      default:  DO = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uartio.sv
// Self-checking bench for uartio: randomized bytes/divisors against a waveform
// and RX-buffer reference model. Build depth follows UARTIO_FIFO_EN.
module tb_uartio;

`ifdef UARTIO_FIFO_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] AD = 3'd0;
  logic [7:0] DI = 8'h00;
  logic [7:0] DO;
  logic       rw = 1'b1;
  logic       cs = 1'b0;
  logic       irq;
  logic       rxd = 1'b1;
  logic       txd;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rxq[$];
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;

  uartio #(.DEFAULT_DIV(16'd103), .FIFO_AW(4)) dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
    .irq(irq), .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk); cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    @(posedge clk); #1; cs = 1'b0; rw = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk); cs = 1'b1; rw = 1'b1; AD = a;
    #1 d = DO;
    @(posedge clk); #1; cs = 1'b0;
  endtask

  task automatic set_div(input int div);
    logic [15:0] d16;
    d16 = div[15:0];
    bus_wr(3'd3, d16[7:0]);
    bus_wr(3'd4, d16[15:8]);
  endtask

  // ideal txd, one sample per clock, for nfr frames
  function automatic logic [199:0] model_wave(input logic [7:0] b0, input logic [7:0] b1,
                                              input int nfr, input int div);
    logic [199:0] w;
    logic [9:0]   fr;
    int p;
    w = '0; p = 0;
    for (int f = 0; f < nfr; f++) begin
      fr = {1'b1, (f == 0) ? b0 : b1, 1'b0};
      for (int k = 0; k < 10; k++)
        for (int c = 0; c <= div; c++) begin
          w[p] = fr[k];
          p++;
        end
    end
    return w;
  endfunction

  task automatic cap_tx(input int n, output logic [199:0] w, output bit ok);
    ok = 1'b0; w = '0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (txd === 1'b0) ok = 1'b1;
    end
    if (ok) begin
      w[0] = txd;
      for (int j = 1; j < n; j++) begin
        @(negedge clk);
        w[j] = txd;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopv, input int div);
    @(negedge clk); rxd = 1'b0;
    repeat (div + 1) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      repeat (div + 1) @(negedge clk);
    end
    rxd = stopv;
    repeat (div + 1) @(negedge clk);
    rxd = 1'b1;
    repeat (div + 4) @(negedge clk);
  endtask

  function automatic void model_rx(input logic [7:0] b, input logic stopv);
    if (!stopv) m_ferr = 1'b1;
    if (rxq.size() < DEPTH) rxq.push_back(b);
    else                    m_ovr = 1'b1;
  endfunction

  task automatic test_reset();
    logic [7:0] exp_tab [8];
    logic [7:0] d;
    exp_tab = '{8'h00, 8'h12, 8'h00, 8'h67, 8'h00, 8'h00, 8'h00, 8'h00};
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_vec++;
    if ({txd, irq} !== 2'b10) begin
      n_err++; $display("FAIL reset_pins: txd,irq=%b required 10", {txd, irq});
    end
    @(negedge clk); rst = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus_rd(a[2:0], d);
      n_vec++;
      if (d !== exp_tab[a]) begin
        n_err++; $display("FAIL reset_reg%0d: got %h required %h", a, d, exp_tab[a]);
      end
    end
  endtask

  task automatic test_regs();
    logic [15:0] dv;
    logic [7:0]  d;
    dv = 16'($urandom);
    bus_wr(3'd3, dv[7:0]); bus_wr(3'd4, dv[15:8]);
    bus_rd(3'd3, d); n_vec++;
    if (d !== dv[7:0]) begin n_err++; $display("FAIL divl_rw: got %h required %h", d, dv[7:0]); end
    bus_rd(3'd4, d); n_vec++;
    if (d !== dv[15:8]) begin n_err++; $display("FAIL divh_rw: got %h required %h", d, dv[15:8]); end
    for (int a = 5; a < 8; a++) begin
      bus_wr(a[2:0], 8'($urandom));
      bus_rd(a[2:0], d); n_vec++;
      if (d !== 8'h00) begin n_err++; $display("FAIL unused_reg%0d: got %h required 00", a, d); end
    end
    bus_wr(3'd2, 8'h83);
    bus_rd(3'd2, d); n_vec++;
    if (d !== 8'h03) begin n_err++; $display("FAIL ctrl_rw: got %h required 03", d); end
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL ctrl_txie_irq: got %b required 1", irq); end
    bus_wr(3'd2, 8'h00);
  endtask

  task automatic tx_check(input logic [7:0] b, input int div, input string nm);
    logic [199:0] w, e;
    bit ok;
    logic [7:0] s;
    set_div(div);
    bus_wr(3'd0, b);
    cap_tx(10 * (div + 1), w, ok);
    e = model_wave(b, 8'h00, 1, div);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL %s_start: no start bit seen, required one", nm);
    end else if (w !== e) begin
      n_err++; $display("FAIL %s: byte %h div %0d wave %h required %h", nm, b, div, w, e);
    end
    repeat (3) @(posedge clk);
    bus_rd(3'd1, s); n_vec++;
    if ({s[4], s[1]} !== 2'b11) begin
      n_err++; $display("FAIL %s_idle: stat %h required b4,b1 set", nm, s);
    end
  endtask

  task automatic test_tx();
    tx_check(8'hA5, 3, "tx_a5");
    for (int i = 0; i < 3; i++) tx_check(8'($urandom), int'($urandom_range(2, 9)), "tx_rand");
  endtask

  task automatic test_back_to_back();
    logic [199:0] w, e;
    bit ok;
    logic [7:0] b0, b1;
    b0 = 8'($urandom); b1 = 8'($urandom);
    set_div(3);
    bus_wr(3'd0, b0);
    bus_wr(3'd0, b1);
    cap_tx(80, w, ok);
    e = model_wave(b0, b1, 2, 3);
    n_vec++;
    if (!ok || w !== e) begin
      n_err++; $display("FAIL back_to_back: wave %h required %h", w, e);
    end
  endtask

  task automatic test_div_midframe();
    logic [199:0] w, e;
    bit ok;
    logic [7:0] b0, b1;
    b0 = 8'($urandom); b1 = 8'($urandom);
    set_div(3);
    bus_wr(3'd0, b0);
    fork
      cap_tx(40, w, ok);
      begin repeat (8) @(posedge clk); bus_wr(3'd3, 8'd7); end
    join
    e = model_wave(b0, 8'h00, 1, 3);
    n_vec++;
    if (!ok || w !== e) begin
      n_err++; $display("FAIL div_midframe: wave %h required %h", w, e);
    end
    bus_wr(3'd0, b1);
    cap_tx(80, w, ok);
    e = model_wave(b1, 8'h00, 1, 7);
    n_vec++;
    if (!ok || w !== e) begin
      n_err++; $display("FAIL div_next_frame: wave %h required %h", w, e);
    end
  endtask

  task automatic test_rx();
    logic [7:0] b, d, s, ex;
    int div;
    bus_wr(3'd2, 8'h01);
    for (int i = 0; i < 4; i++) begin
      div = int'($urandom_range(3, 7));
      set_div(div);
      b = (i == 0) ? 8'h3C : 8'($urandom);
      send_frame(b, 1'b1, div);
      model_rx(b, 1'b1);
      bus_rd(3'd1, s); n_vec++;
      if ({s[3], s[2], s[0]} !== {m_ferr, m_ovr, 1'b1}) begin
        n_err++; $display("FAIL rx_stat: stat %h required ferr %b ovr %b avail 1", s, m_ferr, m_ovr);
      end
      n_vec++;
      if (irq !== 1'b1) begin n_err++; $display("FAIL rx_irq: got %b required 1", irq); end
      bus_rd(3'd0, d);
      ex = rxq.pop_front();
      n_vec++;
      if (d !== ex) begin n_err++; $display("FAIL rx_data: got %h required %h", d, ex); end
      bus_rd(3'd1, s); n_vec++;
      if (s[0] !== 1'b0) begin n_err++; $display("FAIL rx_drain: stat %h required b0 clear", s); end
      n_vec++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL rx_irq_clr: got %b required 0", irq); end
    end
    bus_wr(3'd2, 8'h00);
  endtask

  task automatic test_overrun();
    logic [7:0] d, s, ex;
    set_div(3);
    for (int i = 0; i <= DEPTH; i++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1, 3);
      model_rx(d, 1'b1);
    end
    bus_rd(3'd1, s); n_vec++;
    if ({s[2], s[0]} !== {m_ovr, 1'b1}) begin
      n_err++; $display("FAIL ovr_stat: stat %h required ovr %b avail 1", s, m_ovr);
    end
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL ovr_irq: got %b required 1", irq); end
    for (int i = 0; i < DEPTH; i++) begin
      bus_rd(3'd0, d);
      ex = rxq.pop_front();
      n_vec++;
      if (d !== ex) begin n_err++; $display("FAIL ovr_data%0d: got %h required %h", i, d, ex); end
    end
    bus_wr(3'd2, 8'h80);
    m_ovr = 1'b0; rxq.delete();
    bus_rd(3'd1, s); n_vec++;
    if ({s[2], s[0]} !== 2'b00) begin n_err++; $display("FAIL ovr_clear: stat %h required b2,b0 clear", s); end
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL ovr_irq_clr: got %b required 0", irq); end
  endtask

  task automatic test_frame_err_glitch();
    logic [7:0] b, d, s, ex;
    set_div(3);
    b = 8'($urandom);
    send_frame(b, 1'b0, 3);
    model_rx(b, 1'b0);
    bus_rd(3'd1, s); n_vec++;
    if ({s[3], s[0]} !== {m_ferr, 1'b1}) begin
      n_err++; $display("FAIL ferr_stat: stat %h required ferr 1 avail 1", s);
    end
    bus_rd(3'd0, d);
    ex = rxq.pop_front();
    n_vec++;
    if (d !== ex) begin n_err++; $display("FAIL ferr_data: got %h required %h", d, ex); end
    bus_wr(3'd2, 8'h80);
    m_ferr = 1'b0;
    bus_rd(3'd1, s); n_vec++;
    if (s[3] !== 1'b0) begin n_err++; $display("FAIL ferr_clear: stat %h required b3 clear", s); end
    @(negedge clk); rxd = 1'b0;
    @(negedge clk); rxd = 1'b1;
    repeat (60) @(negedge clk);
    bus_rd(3'd1, s); n_vec++;
    if ({s[3], s[0]} !== 2'b00) begin n_err++; $display("FAIL glitch_stat: stat %h required b3,b0 clear", s); end
    bus_rd(3'd0, d); n_vec++;
    if (d !== 8'h00) begin n_err++; $display("FAIL glitch_data: got %h required 00", d); end
  endtask

  task automatic test_tx_irq();
    set_div(3);
    bus_wr(3'd2, 8'h02);
    @(posedge clk); #1;
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL txirq_idle: got %b required 1", irq); end
    bus_wr(3'd0, 8'($urandom));
    @(posedge clk); #1;
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL txirq_busy: got %b required 0", irq); end
    repeat (39) @(posedge clk); #1;
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL txirq_stop: got %b required 0", irq); end
    repeat (3) @(posedge clk); #1;
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL txirq_done: got %b required 1", irq); end
    bus_wr(3'd2, 8'h00);
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    bit ok;
    set_div(3);
    bus_wr(3'd0, 8'h00);
    repeat (10) @(posedge clk); #1;
    n_vec++;
    if (txd !== 1'b0) begin n_err++; $display("FAIL midrst_pre: txd %b required 0", txd); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (txd !== 1'b1) begin n_err++; $display("FAIL midrst_txd: txd %b required 1", txd); end
    @(negedge clk); rst = 1'b1;
    rxq.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
    bus_rd(3'd3, d); n_vec++;
    if (d !== 8'h67) begin n_err++; $display("FAIL midrst_divl: got %h required 67", d); end
    bus_rd(3'd4, d); n_vec++;
    if (d !== 8'h00) begin n_err++; $display("FAIL midrst_divh: got %h required 00", d); end
    bus_rd(3'd1, d); n_vec++;
    if (d !== 8'h12) begin n_err++; $display("FAIL midrst_stat: got %h required 12", d); end
    ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) ok = 1'b0;
    end
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL midrst_quiet: txd toggled, required steady 1"); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_tx();
    test_back_to_back();
    test_div_midframe();
    test_rx();
    test_overrun();
    test_frame_err_glitch();
    test_tx_irq();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
